// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle PC sequencer (fetch/exec/trap/halt) with retired and taken-branch counters
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             inst_valid,
   input  logic             NextPCsrc,
   input  logic [31:0]      alu_res,
   input  logic             stall,
   input  logic             halt,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             trap,
   output logic [31:0]      trap_pc,
   output logic             halted,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] taken_cnt
);
   typedef enum logic [1:0] {FETCH, EXEC, TRAP, HALTED} state_e;
   state_e             state_q;
   logic [31:0]        pc_q, trap_pc_q;
   logic [CNT_W-1:0]   ret_q, tkn_q;
   logic               misaligned;
   assign misaligned = NextPCsrc && (alu_res[1:0] != 2'b00);
   assign pc_plus4   = pc_q + 32'd4;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         trap_pc_q <= 32'd0;
         ret_q     <= '0;
         tkn_q     <= '0;
      end else begin
         case (state_q)
            FETCH:  if (imem_ready) state_q <= EXEC;
            EXEC: if (!stall) begin
               if (halt) begin
                  state_q <= HALTED;
                  ret_q   <= ret_q + 1'b1;
               end else if (misaligned) begin
                  state_q   <= TRAP;
                  trap_pc_q <= pc_q;
               end else begin
                  state_q <= FETCH;
                  pc_q    <= NextPCsrc ? alu_res : pc_plus4;
                  ret_q   <= ret_q + 1'b1;
                  tkn_q   <= tkn_q + {{(CNT_W-1){1'b0}}, NextPCsrc};
               end
            end
            TRAP: begin
               state_q <= FETCH;
               pc_q    <= TRAP_PC;
            end
            HALTED: ;
         endcase
      end
   end
   // Status strobes are decoded from state but suppressed in any reset cycle.
   assign imem_req    = !rst && state_q == FETCH;
   assign inst_valid  = !rst && state_q == EXEC;
   assign trap        = !rst && state_q == TRAP;
   assign halted      = !rst && state_q == HALTED;
   assign pc          = pc_q;
   assign trap_pc     = trap_pc_q;
   assign retired_cnt = ret_q;
   assign taken_cnt   = tkn_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven per-cycle vectors checked through an expected-value queue
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1, imem_ready = 1'b0, NextPCsrc = 1'b0, stall = 1'b0, halt = 1'b0;
   logic [31:0] alu_res = 32'd0;
   logic        imem_req, inst_valid, trap, halted;
   logic [31:0] pc, pc_plus4, trap_pc, retired_cnt, taken_cnt;
   int          checks = 0, errors = 0;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready),
      .inst_valid(inst_valid), .NextPCsrc(NextPCsrc), .alu_res(alu_res),
      .stall(stall), .halt(halt), .pc(pc), .pc_plus4(pc_plus4), .trap(trap),
      .trap_pc(trap_pc), .halted(halted), .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, rdy, stl, hlt, nps;
      logic [31:0] alu;
      logic [3:0]  fl;
      logic [31:0] pc, tp, r, t;
   } vec_t;

   vec_t vs[$];
   vec_t sb[$];

   function automatic vec_t v(logic rs, logic rd, logic st, logic hl, logic np, logic [31:0] al,
                              logic [3:0] fl, logic [31:0] p, logic [31:0] tp, logic [31:0] r, logic [31:0] t);
      vec_t x;
      x.rst = rs; x.rdy = rd; x.stl = st; x.hlt = hl; x.nps = np; x.alu = al;
      x.fl = fl; x.pc = p; x.tp = tp; x.r = r; x.t = t;
      return x;
   endfunction

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(vec_t x);
      @(posedge clk);
      #1;
      rst = x.rst; imem_ready = x.rdy; stall = x.stl; halt = x.hlt; NextPCsrc = x.nps; alu_res = x.alu;
      sb.push_back(x);
   endtask

   task automatic sample(int idx);
      vec_t e;
      @(negedge clk);
      e = sb.pop_front();
      chk("flags{req,iv,trap,halted}", idx, {28'd0, imem_req, inst_valid, trap, halted}, {28'd0, e.fl});
      chk("pc", idx, pc, e.pc);
      chk("pc_plus4", idx, pc_plus4, e.pc + 32'd4);
      chk("trap_pc", idx, trap_pc, e.tp);
      chk("retired_cnt", idx, retired_cnt, e.r);
      chk("taken_cnt", idx, taken_cnt, e.t);
   endtask

   initial begin
      // flags order: imem_req, inst_valid, trap, halted; each row = inputs for a cycle and outputs seen in it
      vs.push_back(v(1,0,0,0,0,0,          4'b0000, 32'h0,   0, 0, 0));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h0,   0, 0, 0));
      vs.push_back(v(0,0,0,0,0,0,          4'b0100, 32'h0,   0, 0, 0));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h4,   0, 1, 0));
      vs.push_back(v(0,0,0,0,0,0,          4'b0100, 32'h4,   0, 1, 0));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h8,   0, 2, 0));
      vs.push_back(v(0,0,0,0,0,0,          4'b0100, 32'h8,   0, 2, 0));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'hC,   0, 3, 0));
      vs.push_back(v(0,0,0,0,1,32'h8,      4'b0100, 32'hC,   0, 3, 0));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h8,   0, 4, 1));
      vs.push_back(v(0,0,0,0,1,32'h40,     4'b0100, 32'h8,   0, 4, 1));
      vs.push_back(v(0,0,1,1,1,32'h3,      4'b1000, 32'h40,  0, 5, 2));
      vs.push_back(v(0,0,0,0,0,0,          4'b1000, 32'h40,  0, 5, 2));
      vs.push_back(v(0,0,0,0,0,0,          4'b1000, 32'h40,  0, 5, 2));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h40,  0, 5, 2));
      vs.push_back(v(0,0,1,1,1,32'h3,      4'b0100, 32'h40,  0, 5, 2));
      vs.push_back(v(0,0,1,0,1,32'h80,     4'b0100, 32'h40,  0, 5, 2));
      vs.push_back(v(0,0,0,0,0,0,          4'b0100, 32'h40,  0, 5, 2));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h44,  0, 6, 2));
      vs.push_back(v(0,0,0,0,1,32'h20,     4'b0100, 32'h44,  0, 6, 2));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h20,  0, 7, 3));
      vs.push_back(v(0,0,0,0,1,32'h42,     4'b0100, 32'h20,  0, 7, 3));
      vs.push_back(v(0,1,1,1,1,32'h8,      4'b0010, 32'h20,  32'h20, 7, 3));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h100, 32'h20, 7, 3));
      vs.push_back(v(0,0,0,0,1,32'hFFFF_FFFC, 4'b0100, 32'h100, 32'h20, 7, 3));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'hFFFF_FFFC, 32'h20, 8, 4));
      vs.push_back(v(0,0,0,0,0,0,          4'b0100, 32'hFFFF_FFFC, 32'h20, 8, 4));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h0,   32'h20, 9, 4));
      vs.push_back(v(0,1,0,1,1,32'h80,     4'b0100, 32'h0,   32'h20, 9, 4));
      vs.push_back(v(0,1,1,0,1,32'h84,     4'b0001, 32'h0,   32'h20, 10, 4));
      vs.push_back(v(0,1,0,0,0,0,          4'b0001, 32'h0,   32'h20, 10, 4));
      vs.push_back(v(0,0,0,1,0,0,          4'b0001, 32'h0,   32'h20, 10, 4));
      vs.push_back(v(1,0,0,0,0,0,          4'b0000, 32'h0,   32'h20, 10, 4));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h0,   0, 0, 0));
      vs.push_back(v(0,0,0,0,0,0,          4'b0100, 32'h0,   0, 0, 0));
      vs.push_back(v(0,1,0,0,0,0,          4'b1000, 32'h4,   0, 1, 0));
      vs.push_back(v(0,0,1,0,0,0,          4'b0100, 32'h4,   0, 1, 0));
      vs.push_back(v(1,0,1,0,1,32'h40,     4'b0000, 32'h4,   0, 1, 0));
      vs.push_back(v(0,0,0,0,0,0,          4'b1000, 32'h0,   0, 0, 0));
      @(posedge clk);
      for (int i = 0; i < vs.size(); i++) begin
         drive(vs[i]);
         sample(i);
      end
      // Hand sequence: reset in the middle of a wait-stated fetch after a taken branch.
      drive(v(0,1,0,0,0,0,      4'b1000, 32'h0,   0, 0, 0)); sample(100);
      drive(v(0,0,0,0,1,32'h200,4'b0100, 32'h0,   0, 0, 0)); sample(101);
      drive(v(0,0,0,0,0,0,      4'b1000, 32'h200, 0, 1, 1)); sample(102);
      drive(v(1,0,0,0,0,0,      4'b0000, 32'h200, 0, 1, 1)); sample(103);
      drive(v(0,0,0,0,0,0,      4'b1000, 32'h0,   0, 0, 0)); sample(104);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
